// File: rtl/alrd_arb_axis.sv
// Read-address arbiter: N upstream requesters share one downstream read port.
// Round-robin address arbitration with grant lock while stalled; an in-order
// FIFO of granted port indices routes returning data beats back to requesters.
module alrd_arb_axis #(
    parameter int PORTS           = 2,
    parameter int ADDR_WIDTH      = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [PORTS*ADDR_WIDTH-1:0]         s_al_araddr,
    input  logic [PORTS-1:0]                    s_al_arvalid,
    input  logic [PORTS*ID_WIDTH-1:0]           s_al_arid,
    output logic [PORTS-1:0]                    s_al_arready,
    output logic [PORTS*DATA_WIDTH-1:0]         s_al_rdata,
    output logic [PORTS-1:0]                    s_al_rvalid,
    output logic [PORTS*ID_WIDTH-1:0]           s_al_rid,
    input  logic [PORTS-1:0]                    s_al_rready,
    output logic [ADDR_WIDTH-1:0]               m_al_araddr,
    output logic                                m_al_arvalid,
    output logic [ID_WIDTH-1:0]                 m_al_arid,
    input  logic                                m_al_arready,
    input  logic [DATA_WIDTH-1:0]               m_al_rdata,
    input  logic                                m_al_rvalid,
    input  logic [ID_WIDTH-1:0]                 m_al_rid,
    output logic                                m_al_rready,
    output logic                                err_orphan_r,
    output logic [$clog2(MAX_OUTSTANDING):0]    outstanding
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(PORTS);
    localparam logic [PORTS-1:0] ONE_HOT0 = {{(PORTS-1){1'b0}}, 1'b1};

    logic [IW-1:0] r_fifo [MAX_OUTSTANDING];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_lock;
    logic [IW-1:0] r_lock_idx;
    logic [IW-1:0] r_last;
    logic          r_err;
    logic          r_rst_d;

    logic [IW-1:0] w_rr_idx;
    logic          w_rr_found;
    logic [IW-1:0] w_grant;
    logic          w_req;
    logic          w_full;
    logic          w_empty;
    logic          w_quiet;
    logic          w_push;
    logic          w_pop;
    logic [IW-1:0] w_head;
    logic          w_rd_ok;

    // Round-robin search starting just after the last granted port, wrapping.
    always_comb begin
        w_rr_idx   = '0;
        w_rr_found = 1'b0;
        for (int k = 1; k <= PORTS; k++) begin
            if (!w_rr_found && s_al_arvalid[(int'(r_last) + k) % PORTS]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = IW'((int'(r_last) + k) % PORTS);
            end
        end
    end

    // Address and data routing; all handshakes suppressed during and one cycle after reset.
    always_comb begin
        w_quiet      = rst | r_rst_d;
        w_full       = (r_count == CW'(MAX_OUTSTANDING));
        w_empty      = (r_count == '0);
        w_grant      = r_lock ? r_lock_idx : w_rr_idx;
        w_req        = r_lock | w_rr_found;
        m_al_arvalid = ~w_quiet & ~w_full & w_req & s_al_arvalid[w_grant];
        m_al_araddr  = s_al_araddr[w_grant*ADDR_WIDTH +: ADDR_WIDTH];
        m_al_arid    = s_al_arid[w_grant*ID_WIDTH +: ID_WIDTH];
        w_push       = m_al_arvalid & m_al_arready;
        s_al_arready = w_push ? (ONE_HOT0 << w_grant) : '0;

        w_head       = r_fifo[r_rd_ptr];
        w_rd_ok      = ~w_quiet & ~w_empty;
        s_al_rvalid  = (w_rd_ok & m_al_rvalid) ? (ONE_HOT0 << w_head) : '0;
        m_al_rready  = w_rd_ok & s_al_rready[w_head];
        w_pop        = m_al_rvalid & m_al_rready;
        s_al_rdata   = {PORTS{m_al_rdata}};
        s_al_rid     = {PORTS{m_al_rid}};
        err_orphan_r = r_err;
        outstanding  = r_count;
    end

    // Grant FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_grant;
        end
    end

    // Pointers, occupancy, lock, round-robin history and the sticky orphan flag.
    always_ff @(posedge clk) begin
        r_rst_d <= rst;
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_last     <= IW'(PORTS - 1);
            r_err      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                r_last   <= w_grant;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Hold the grant only while the downstream is stalling a presented request.
            r_lock     <= m_al_arvalid & ~m_al_arready;
            r_lock_idx <= w_grant;
            if (m_al_rvalid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alrd_arb_axis.sv
// Bench for alrd_arb_axis: directed scenarios followed by randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_alrd_arb_axis;

    localparam int P  = 3;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam int MO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [P*AW-1:0]   s_al_araddr;
    logic [P-1:0]      s_al_arvalid;
    logic [P*IW-1:0]   s_al_arid;
    logic [P-1:0]      s_al_arready;
    logic [P*DW-1:0]   s_al_rdata;
    logic [P-1:0]      s_al_rvalid;
    logic [P*IW-1:0]   s_al_rid;
    logic [P-1:0]      s_al_rready;
    logic [AW-1:0]     m_al_araddr;
    logic              m_al_arvalid;
    logic [IW-1:0]     m_al_arid;
    logic              m_al_arready;
    logic [DW-1:0]     m_al_rdata;
    logic              m_al_rvalid;
    logic [IW-1:0]     m_al_rid;
    logic              m_al_rready;
    logic              err_orphan_r;
    logic [$clog2(MO):0] outstanding;

    logic [AW-1:0] addr [P];
    logic [IW-1:0] id   [P];
    logic [P-1:0]  arv;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    int q[$];
    int last_g;
    bit lk;
    int lk_port;
    bit orph;
    bit post_rst;
    logic [P-1:0] last_hs;

    // DUT values captured at the last sample point
    logic [P-1:0]  obs_arready;
    logic [AW-1:0] obs_araddr;
    logic [$clog2(MO):0] obs_out;
    logic          obs_err;

    alrd_arb_axis #(
        .PORTS(P), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_al_araddr(s_al_araddr), .s_al_arvalid(s_al_arvalid), .s_al_arid(s_al_arid),
        .s_al_arready(s_al_arready), .s_al_rdata(s_al_rdata), .s_al_rvalid(s_al_rvalid),
        .s_al_rid(s_al_rid), .s_al_rready(s_al_rready),
        .m_al_araddr(m_al_araddr), .m_al_arvalid(m_al_arvalid), .m_al_arid(m_al_arid),
        .m_al_arready(m_al_arready), .m_al_rdata(m_al_rdata), .m_al_rvalid(m_al_rvalid),
        .m_al_rid(m_al_rid), .m_al_rready(m_al_rready),
        .err_orphan_r(err_orphan_r), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    always_comb begin
        s_al_araddr  = '0;
        s_al_arid    = '0;
        for (int p = 0; p < P; p++) begin
            s_al_araddr[p*AW +: AW] = addr[p];
            s_al_arid[p*IW +: IW]   = id[p];
        end
        s_al_arvalid = arv;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // One clock cycle: predict and compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit quiet, full, empty, found, e_arv, e_hs, e_rv, e_rr, e_pop;
        int g, head;
        @(negedge clk);
        quiet = rst || post_rst;
        full  = (q.size() == MO);
        empty = (q.size() == 0);
        head  = empty ? 0 : q[0];
        found = 0;
        g     = 0;
        if (lk) begin
            found = 1;
            g     = lk_port;
        end else begin
            for (int k = 1; k <= P; k++) begin
                if (!found && arv[(last_g + k) % P]) begin
                    found = 1;
                    g     = (last_g + k) % P;
                end
            end
        end
        e_arv = !quiet && !full && found && arv[g];
        e_hs  = e_arv && m_al_arready;
        e_rv  = !quiet && !empty && m_al_rvalid;
        e_rr  = !quiet && !empty && s_al_rready[head];
        e_pop = m_al_rvalid && e_rr;

        obs_arready = s_al_arready;
        obs_araddr  = m_al_araddr;
        obs_out     = outstanding;
        obs_err     = err_orphan_r;

        chk("m_arvalid", m_al_arvalid, e_arv);
        if (e_arv) begin
            chk("m_araddr", m_al_araddr, addr[g]);
            chk("m_arid", m_al_arid, id[g]);
        end
        chk("s_arready", s_al_arready, e_hs ? (1 << g) : 0);
        chk("s_rvalid", s_al_rvalid, e_rv ? (1 << head) : 0);
        chk("m_rready", m_al_rready, e_rr);
        if (e_rv) begin
            chk("s_rdata", s_al_rdata[head*DW +: DW], m_al_rdata);
            chk("s_rid", s_al_rid[head*IW +: IW], m_al_rid);
        end
        chk("outstanding", outstanding, q.size());
        chk("err_orphan", err_orphan_r, orph);

        @(posedge clk);
        last_hs = e_hs ? P'(1 << g) : '0;
        if (rst) begin
            q.delete();
            last_g   = P - 1;
            lk       = 0;
            orph     = 0;
            post_rst = 1;
        end else begin
            post_rst = 0;
            if (m_al_rvalid && empty) orph = 1;
            if (e_pop) void'(q.pop_front());
            if (e_hs) begin
                q.push_back(g);
                last_g = g;
            end
            lk      = e_arv && !m_al_arready;
            lk_port = g;
        end
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        arv          = '0;
        m_al_rvalid  = 1'b0;
        m_al_arready = 1'b0;
        s_al_rready  = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        arv          = '0;
        for (int p = 0; p < P; p++) begin
            addr[p] = '0;
            id[p]   = '0;
        end
        m_al_arready = 1'b0;
        m_al_rvalid  = 1'b0;
        m_al_rdata   = '0;
        m_al_rid     = '0;
        s_al_rready  = '0;
        q.delete();
        last_g   = P - 1;
        lk       = 0;
        lk_port  = 0;
        orph     = 0;
        post_rst = 1;
        repeat (2) @(posedge clk);
        #1;

        // Round-robin alternation between two continuously requesting ports.
        do_reset();
        arv          = 3'b011;
        addr[0]      = 4'h1;
        addr[1]      = 4'h2;
        m_al_arready = 1'b1;
        step();  // cycle after reset: everything held off
        chk("post_rst_arready", obs_arready, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_alt", obs_arready, (k % 2 == 0) ? 1 : 2);
        end

        // Grant lock: port 1 stalled at address 5, port 0 arrives later.
        do_reset();
        step();
        arv          = 3'b010;
        addr[1]      = 4'h5;
        addr[0]      = 4'h9;
        m_al_arready = 1'b0;
        step();
        arv[0] = 1'b1;
        step();
        step();
        chk("lock_addr", obs_araddr, 5);
        m_al_arready = 1'b1;
        step();
        chk("lock_release", obs_arready, 3'b010);
        arv[1] = 1'b0;
        step();
        chk("after_lock", obs_arready, 3'b001);

        // Outstanding limit and the pop-then-accept timing.
        do_reset();
        step();
        arv          = 3'b001;
        addr[0]      = 4'h3;
        m_al_arready = 1'b1;
        repeat (5) step();
        chk("full_stall", obs_arready, 0);
        chk("full_count", obs_out, 4);
        m_al_rvalid  = 1'b1;
        m_al_rdata   = 32'hA;
        s_al_rready  = 3'b001;
        step();
        chk("no_bypass", obs_arready, 0);
        m_al_rvalid = 1'b0;
        step();
        chk("refill", obs_arready, 3'b001);
        arv = '0;
        step();
        chk("refill_count", obs_out, 4);

        // Reset mid-transaction, then a late response is an orphan.
        do_reset();
        step();
        arv          = 3'b001;
        m_al_arready = 1'b1;
        repeat (2) step();
        arv = '0;
        do_reset();
        m_al_rvalid = 1'b1;
        step();
        m_al_rvalid = 1'b0;
        step();
        chk("orphan_set", obs_err, 1);
        repeat (3) step();
        chk("orphan_sticky", obs_err, 1);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom % 400 == 0);
            if (rst) arv = '0;
            else begin
                for (int p = 0; p < P; p++) begin
                    if (!arv[p] && ($urandom % 3 == 0)) begin
                        arv[p]  = 1'b1;
                        addr[p] = AW'($urandom);
                        id[p]   = IW'($urandom);
                    end
                end
            end
            m_al_arready = ($urandom % 4 != 0);
            m_al_rvalid  = (q.size() > 0) && ($urandom % 5 < 3);
            m_al_rdata   = $urandom;
            m_al_rid     = IW'($urandom);
            s_al_rready  = P'($urandom);
            step();
            arv = arv & ~last_hs;
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
